// File: rtl/hes_block_loader.sv
// Packs a valid/ready byte stream into a zero-padded block for the HES core; latches key/direction.
// new_message one cycle after the closing beat, input_valid the cycle after; s_ready low from KEY until blk_ack.
module hes_block_loader #(
  parameter int BLOCK_BYTES = 256,
  parameter int CNT_W       = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  input  logic [7:0]               s_key,
  input  logic                     s_is_ct,
  output logic                     s_ready,
  output logic [8*BLOCK_BYTES-1:0] blk_data,
  output logic [CNT_W-1:0]         blk_len,
  output logic                     blk_trunc,
  output logic [7:0]               key_out,
  output logic                     is_ciphertext,
  output logic                     new_message,
  output logic                     input_valid,
  input  logic                     blk_ack
);

  localparam int IDX_W = $clog2(8*BLOCK_BYTES);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BLOCK_BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, KEY, ISSUE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [IDX_W-1:0] wr_idx;
  logic             beat;

  assign beat    = s_valid && s_ready;
  assign cnt_inc = cnt + CNT_W'(1);
  // cnt is below BLOCK_BYTES whenever a LOAD write happens, so the bit index stays in range
  assign wr_idx  = IDX_W'({cnt, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      s_ready       <= 1'b0;
      blk_data      <= '0;
      blk_len       <= '0;
      blk_trunc     <= 1'b0;
      key_out       <= 8'h00;
      is_ciphertext <= 1'b0;
      new_message   <= 1'b0;
      input_valid   <= 1'b0;
    end else begin
      new_message <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (beat) begin
            blk_data      <= {{(8*BLOCK_BYTES-8){1'b0}}, s_data};
            key_out       <= s_key;
            is_ciphertext <= s_is_ct;
            cnt           <= CNT_W'(1);
            blk_trunc     <= 1'b0;
            if (s_last) begin
              state       <= KEY;
              s_ready     <= 1'b0;
              new_message <= 1'b1;
              blk_len     <= CNT_W'(1);
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            blk_data[wr_idx +: 8] <= s_data;
            cnt                   <= cnt_inc;
            // s_last wins over a full buffer on the same beat
            if (s_last || cnt_inc == FULL) begin
              state       <= KEY;
              s_ready     <= 1'b0;
              new_message <= 1'b1;
              blk_len     <= cnt_inc;
              blk_trunc   <= !s_last;
            end
          end
        end
        KEY: begin
          state       <= ISSUE;
          input_valid <= 1'b1;
        end
        ISSUE: begin
          if (blk_ack) begin
            state       <= IDLE;
            input_valid <= 1'b0;
            s_ready     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hes_block_loader.sv
// Directed bench for hes_block_loader: reset, short/full/truncated blocks, backpressure, mid-message reset, key hold.
module tb_hes_block_loader;

  localparam int BB = 256;
  localparam int CW = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      s_data = 8'h00;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic [7:0]      s_key = 8'h00;
  logic            s_is_ct = 1'b0;
  logic            s_ready;
  logic [8*BB-1:0] blk_data;
  logic [CW-1:0]   blk_len;
  logic            blk_trunc;
  logic [7:0]      key_out;
  logic            is_ciphertext;
  logic            new_message;
  logic            input_valid;
  logic            blk_ack = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_mem [BB];

  hes_block_loader #(.BLOCK_BYTES(BB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_key(s_key), .s_is_ct(s_is_ct), .s_ready(s_ready), .blk_data(blk_data),
    .blk_len(blk_len), .blk_trunc(blk_trunc), .key_out(key_out),
    .is_ciphertext(is_ciphertext), .new_message(new_message),
    .input_valid(input_valid), .blk_ack(blk_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < BB; i++) exp_mem[i] = 8'h00;
  endtask

  task automatic chk_blk(input string tag);
    int bad = 0;
    for (int i = 0; i < BB; i++)
      if (blk_data[8*i +: 8] !== exp_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // Holds the beat until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] k, input logic c);
    s_data = d; s_last = l; s_key = k; s_is_ct = c; s_valid = 1'b1;
    for (int i = 0; i < 50 && !s_ready; i++) tick();
    if (!s_ready) chk("s_ready_timeout", s_ready, 1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic ack();
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_iv", input_valid, 0);
    chk("rst_newmsg", new_message, 0);
    chk("rst_len", blk_len, 0);
    chk("rst_key", key_out, 0);
    chk("rst_isct", is_ciphertext, 0);
    chk("rst_trunc", blk_trunc, 0);
    clear_exp();
    chk_blk("rst_data");
    rst_n = 1'b1;
    tick();
    chk("post_rst_s_ready", s_ready, 1);

    // 1) three-byte message, latency check
    send(8'h11, 0, 8'h3C, 0);
    send(8'h22, 0, 8'h3C, 0);
    send(8'h33, 1, 8'h3C, 0);
    chk("t1_newmsg_n1", new_message, 1);
    chk("t1_iv_n1", input_valid, 0);
    chk("t1_ready_key", s_ready, 0);
    tick();
    chk("t1_newmsg_n2", new_message, 0);
    chk("t1_iv_n2", input_valid, 1);
    chk("t1_len", blk_len, 3);
    chk("t1_trunc", blk_trunc, 0);
    chk("t1_key", key_out, 8'h3C);
    chk("t1_isct", is_ciphertext, 0);
    clear_exp();
    exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33;
    chk_blk("t1_data");
    ack();
    chk("t1_iv_after_ack", input_valid, 0);
    chk("t1_ready_after_ack", s_ready, 1);
    chk("t1_key_hold", key_out, 8'h3C);

    // 2) full 256-byte block closed by s_last
    for (int i = 0; i < BB; i++) send(8'(i), (i == BB-1), 8'hA7, 1);
    chk("t2_newmsg", new_message, 1);
    chk("t2_ready_key", s_ready, 0);
    tick();
    chk("t2_iv", input_valid, 1);
    chk("t2_ready_issue", s_ready, 0);
    chk("t2_len", blk_len, 256);
    chk("t2_trunc", blk_trunc, 0);
    chk("t2_key", key_out, 8'hA7);
    chk("t2_isct", is_ciphertext, 1);
    for (int i = 0; i < BB; i++) exp_mem[i] = 8'(i);
    chk_blk("t2_data");
    ack();

    // 3) 257 bytes, truncation then one-byte follow-up
    for (int i = 0; i < BB; i++) send(8'(i), 0, 8'h5A, 1);
    chk("t3_newmsg", new_message, 1);
    tick();
    chk("t3_len", blk_len, 256);
    chk("t3_trunc", blk_trunc, 1);
    chk_blk("t3_data");
    ack();
    send(8'h00, 1, 8'h5A, 1);
    chk("t3b_newmsg", new_message, 1);
    tick();
    chk("t3b_len", blk_len, 1);
    chk("t3b_trunc", blk_trunc, 0);
    clear_exp();
    chk_blk("t3b_data");

    // 4) backpressure while the block is held
    s_data = 8'h77; s_last = 1'b1; s_key = 8'h19; s_is_ct = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_iv_hold", input_valid, 1);
      chk("t4_ready_hold", s_ready, 0);
      chk("t4_newmsg_hold", new_message, 0);
    end
    chk("t4_len_hold", blk_len, 1);
    chk("t4_key_hold", key_out, 8'h5A);
    ack();
    chk("t4_iv_exit", input_valid, 0);
    chk("t4_ready_exit", s_ready, 1);
    chk("t4_not_consumed", new_message, 0);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("t4_first_beat", new_message, 1);
    tick();
    chk("t4_len", blk_len, 1);
    chk("t4_key", key_out, 8'h19);
    exp_mem[0] = 8'h77;
    chk_blk("t4_data");
    ack();

    // 5) reset in the middle of a message
    for (int i = 0; i < 5; i++) send(8'(8'hE0 + i), 0, 8'h42, 1);
    rst_n = 1'b0;
    #2;
    chk("t5_ready", s_ready, 0);
    chk("t5_len", blk_len, 0);
    chk("t5_key", key_out, 0);
    chk("t5_isct", is_ciphertext, 0);
    chk("t5_iv", input_valid, 0);
    clear_exp();
    chk_blk("t5_data");
    tick(); tick();
    chk("t5_newmsg", new_message, 0);
    rst_n = 1'b1;
    tick();
    chk("t5_newmsg_after", new_message, 0);
    send(8'hAA, 0, 8'h81, 1);
    send(8'hBB, 1, 8'h81, 1);
    tick();
    chk("t5b_len", blk_len, 2);
    chk("t5b_key", key_out, 8'h81);
    chk("t5b_isct", is_ciphertext, 1);
    exp_mem[0] = 8'hAA; exp_mem[1] = 8'hBB;
    chk_blk("t5b_data");
    ack();

    // 6) key/direction only sampled on the first beat; stray ack ignored
    send(8'h01, 0, 8'hC5, 1);
    send(8'h02, 0, 8'h00, 0);
    chk("t6_key_mid", key_out, 8'hC5);
    blk_ack = 1'b1;
    send(8'h03, 0, 8'hFF, 0);
    blk_ack = 1'b0;
    send(8'h04, 1, 8'h12, 0);
    chk("t6_newmsg", new_message, 1);
    tick();
    chk("t6_iv", input_valid, 1);
    chk("t6_len", blk_len, 4);
    chk("t6_key", key_out, 8'hC5);
    chk("t6_isct", is_ciphertext, 1);
    clear_exp();
    exp_mem[0] = 8'h01; exp_mem[1] = 8'h02; exp_mem[2] = 8'h03; exp_mem[3] = 8'h04;
    chk_blk("t6_data");
    ack();
    chk("t6_iv_after_ack", input_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
